// File: rtl/div_result_bcd.sv
// Purpose: capture the divider quotient and convert it to packed BCD, one double-dabble step per clock.
// Latency: bcd_valid pulses WIDTH edges after the valid_in sampling edge; ready for a new value WIDTH+2 cycles after it.
// Backpressure: none; valid_in while busy is dropped and latched into the sticky overrun flag.
module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  valid_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  overrun
);

    // Scratch register layout: {BCD digits, remaining binary bits}.
    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [SW-1:0]  scratch;
    logic [SW-1:0]  adj;
    logic [SW-1:0]  shifted;
    logic [CW-1:0]  count;

    // One double-dabble step: add 3 to every digit >= 5 (no carry between nibbles), then shift left.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[WIDTH + 4*d +: 4] >= 4'd5) begin
                adj[WIDTH + 4*d +: 4] = scratch[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
    end

    // Control FSM with registered outputs; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            scratch   <= '0;
            count     <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        scratch <= {{(4*DIGITS){1'b0}}, bin_in};
                        count   <= CW'(WIDTH);
                        state   <= CONV;
                        busy    <= 1'b1;
                    end
                end
                CONV: begin
                    if (valid_in) begin
                        overrun <= 1'b1;
                    end
                    scratch <= shifted;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // Final shift: the BCD half of the shifted scratch is the result.
                        bcd_out   <= shifted[SW-1:WIDTH];
                        bcd_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (valid_in) begin
                        overrun <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: reset state, conversion values and timing,
// overrun on dropped loads, mid-conversion reset, back-to-back loads, full 0..255 sweep.
module tb_div_result_bcd;

    logic        clk;
    logic        rst;
    logic [7:0]  bin_in;
    logic        valid_in;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .valid_in  (valid_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decimal-to-BCD built from division, independent of the shift algorithm.
    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Load one value and follow it through: latency, pulse width, busy length, result, hold.
    task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp);
        int          vk;
        int          vcnt;
        int          bcnt;
        logic [11:0] got;
        bin_in   = v;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        bin_in   = 8'($urandom);
        vk   = -1;
        vcnt = 0;
        bcnt = busy ? 1 : 0;
        got  = 12'hxxx;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (busy) bcnt++;
            if (bcd_valid) begin
                vcnt++;
                if (vk < 0) begin
                    vk  = k;
                    got = bcd_out;
                end
            end
        end
        check({tag, "_latency"}, 32'(vk), 32'd8);
        check({tag, "_vpulses"}, 32'(vcnt), 32'd1);
        check({tag, "_busycyc"}, 32'(bcnt), 32'd9);
        check({tag, "_value"}, {20'd0, got}, {20'd0, exp});
        check({tag, "_hold"}, {20'd0, bcd_out}, {20'd0, exp});
    endtask

    initial begin
        int          vk;
        int          np;
        logic [11:0] res [3];
        logic [7:0]  q;

        rst      = 1'b0;
        valid_in = 1'b0;
        bin_in   = 8'd0;
        tick();
        tick();
        check("rst_bcd_out", {20'd0, bcd_out}, 32'd0);
        check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        tick();

        // T1 / T2: single conversions including boundaries
        convert("t1_255", 8'd255, 12'h255);
        convert("t2_0", 8'd0, 12'h000);
        convert("t2_128", 8'd128, 12'h128);
        convert("t2_9", 8'd9, 12'h009);
        convert("t2_10", 8'd10, 12'h010);
        check("t2_overrun", {31'd0, overrun}, 32'd0);

        // T3: second load 3 cycles into CONV is dropped and flagged
        bin_in   = 8'd42;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        vk = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) begin
                bin_in   = 8'd7;
                valid_in = 1'b1;
            end
            tick();
            valid_in = 1'b0;
            if (bcd_valid && vk < 0) begin
                vk = k;
                check("t3_value", {20'd0, bcd_out}, 32'h042);
            end
        end
        check("t3_latency", 32'(vk), 32'd8);
        check("t3_overrun", {31'd0, overrun}, 32'd1);
        check("t3_idle", {31'd0, busy}, 32'd0);
        convert("t3_next", 8'd63, 12'h063);
        check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // T4: reset during CONV cycle 4 aborts without a pulse
        bin_in   = 8'd200;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t4_bcd_out", {20'd0, bcd_out}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        check("t4_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bcd_valid) np++;
        end
        check("t4_no_pulse", 32'(np), 32'd0);
        convert("t4_99", 8'd99, 12'h099);

        // T5: loads every 10 cycles
        np = 0;
        for (int t = 0; t < 36; t++) begin
            valid_in = (t == 0 || t == 10 || t == 20);
            bin_in   = (t == 0) ? 8'd17 : (t == 10) ? 8'd250 : (t == 20) ? 8'd64 : 8'($urandom);
            tick();
            valid_in = 1'b0;
            if (bcd_valid) begin
                if (np < 3) res[np] = bcd_out;
                np++;
            end
        end
        check("t5_pulses", 32'(np), 32'd3);
        check("t5_r0", {20'd0, res[0]}, 32'h017);
        check("t5_r1", {20'd0, res[1]}, 32'h250);
        check("t5_r2", {20'd0, res[2]}, 32'h064);
        check("t5_overrun", {31'd0, overrun}, 32'd0);

        // T6: every quotient value, plus a few dividend/divisor pairs incl. divide-by-zero code
        for (int v = 0; v < 256; v++) begin
            convert("t6_sweep", 8'(v), to_bcd(v));
        end
        for (int p = 0; p < 6; p++) begin
            int a;
            int b;
            a = (p == 0) ? 200 : (p == 1) ? 255 : (p == 2) ? 7 : (p == 3) ? 99 : (p == 4) ? 250 : 13;
            b = (p == 0) ? 3 : (p == 1) ? 1 : (p == 2) ? 9 : (p == 3) ? 0 : (p == 4) ? 25 : 0;
            q = (b == 0) ? 8'hFF : 8'(a / b);
            convert("t6_div", q, to_bcd(int'(q)));
        end
        check("t6_overrun", {31'd0, overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
